// File: rtl/lcd_bus_rx_if.sv
// 16-bit 8080-style parallel LCD bus as seen between a host and the panel.
// The master modport is the host side; the slave modport is the panel receiver.
interface lcd_bus_rx_if;
  logic        LCD_CS;
  logic        LCD_RS;
  logic        LCD_WR;
  logic        LCD_RD;
  logic [15:0] LCD_DATA_IN;
  logic [15:0] LCD_DATA_OUT;
  logic        LCD_DATA_OE;

  modport master (
    output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_IN,
    input  LCD_DATA_OUT, LCD_DATA_OE
  );

  modport slave (
    input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_IN,
    output LCD_DATA_OUT, LCD_DATA_OE
  );
endinterface

// File: rtl/lcd_bus_rx.sv
// Panel-side receiver for the 8080 parallel LCD bus: decodes commands, tracks the
// CASET/PASET window, streams RAMWR pixels with coordinates and answers ID readback.
module lcd_bus_rx #(
  parameter int          H_RES       = 240,
  parameter int          V_RES       = 320,
  parameter int          COORD_WIDTH = 10,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_CODE     = 16'h9341
) (
  input  logic                   clk,
  input  logic                   rst,
  lcd_bus_rx_if.slave            bus,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_code,
  output logic                   param_valid,
  output logic [15:0]            param_data,
  output logic [7:0]             param_idx,
  output logic                   pix_valid,
  output logic [COORD_WIDTH-1:0] pix_x,
  output logic [COORD_WIDTH-1:0] pix_y,
  output logic                   proto_err
);

  localparam logic [COORD_WIDTH-1:0] XE_RST = COORD_WIDTH'(H_RES - 1);
  localparam logic [COORD_WIDTH-1:0] YE_RST = COORD_WIDTH'(V_RES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_RDID
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rs_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [15:0]            data_sync [SYNC_STAGES];

  logic        cs_prev;
  logic        wr_prev;
  logic        rd_prev;

  logic        cs_s;
  logic        rs_s;
  logic        wr_s;
  logic        rd_s;
  logic [15:0] data_s;

  logic        wr_rise;
  logic        rd_fall;
  logic        rd_rise;
  logic        cs_rise;
  logic        bus_conflict;

  logic [COORD_WIDTH-1:0] xs;
  logic [COORD_WIDTH-1:0] xe;
  logic [COORD_WIDTH-1:0] ys;
  logic [COORD_WIDTH-1:0] ye;
  logic [COORD_WIDTH-1:0] ptr_x;
  logic [COORD_WIDTH-1:0] ptr_y;
  logic                   x_wrap;
  logic                   y_wrap;

  logic [7:0]  sh_start_hi;
  logic [7:0]  sh_start_lo;
  logic [7:0]  sh_end_hi;
  logic [7:0]  word_cnt;
  logic [7:0]  word_cnt_inc;
  logic [15:0] rd_word;
  logic [15:0] data_out_q;
  logic        oe_q;

  // Idle reset values keep the chain from presenting a false WR/RD edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync <= '1;
      rs_sync <= '0;
      wr_sync <= '1;
      rd_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync[i] <= '0;
      end
      cs_prev <= 1'b1;
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
    end else begin
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], bus.LCD_CS};
      rs_sync      <= {rs_sync[SYNC_STAGES-2:0], bus.LCD_RS};
      wr_sync      <= {wr_sync[SYNC_STAGES-2:0], bus.LCD_WR};
      rd_sync      <= {rd_sync[SYNC_STAGES-2:0], bus.LCD_RD};
      data_sync[0] <= bus.LCD_DATA_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync[i] <= data_sync[i-1];
      end
      cs_prev <= cs_sync[SYNC_STAGES-1];
      wr_prev <= wr_sync[SYNC_STAGES-1];
      rd_prev <= rd_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rs_s   = rs_sync[SYNC_STAGES-1];
  assign wr_s   = wr_sync[SYNC_STAGES-1];
  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  assign wr_rise      = wr_s & ~wr_prev & ~cs_s;
  assign rd_fall      = ~rd_s & rd_prev & ~cs_s & wr_s;
  assign rd_rise      = rd_s & ~rd_prev;
  assign cs_rise      = cs_s & ~cs_prev;
  assign bus_conflict = ~cs_s & ~wr_s & ~rd_s;

  assign word_cnt_inc = (word_cnt == 8'hFF) ? word_cnt : word_cnt + 8'd1;

  // An inverted window (start > end) pins that axis at its start coordinate.
  assign x_wrap = (ptr_x == xe) || (xs > xe);
  assign y_wrap = (ptr_y == ye) || (ys > ye);

  always_comb begin
    rd_word = 16'h0000;
    if (state == ST_RDID) begin
      case (word_cnt)
        8'd2:    rd_word = {8'h00, ID_CODE[15:8]};
        8'd3:    rd_word = {8'h00, ID_CODE[7:0]};
        default: rd_word = 16'h0000;
      endcase
    end
  end

  // Command decode, window shadowing, pixel pointer and readback driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      param_valid <= 1'b0;
      param_data  <= 16'h0000;
      param_idx   <= 8'h00;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      proto_err   <= 1'b0;
      xs          <= '0;
      xe          <= XE_RST;
      ys          <= '0;
      ye          <= YE_RST;
      ptr_x       <= '0;
      ptr_y       <= '0;
      sh_start_hi <= 8'h00;
      sh_start_lo <= 8'h00;
      sh_end_hi   <= 8'h00;
      word_cnt    <= 8'h00;
      data_out_q  <= 16'h0000;
      oe_q        <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      param_valid <= 1'b0;
      pix_valid   <= 1'b0;

      if (bus_conflict) begin
        proto_err <= 1'b1;
      end

      if (wr_rise) begin
        if (!rs_s) begin
          cmd_valid <= 1'b1;
          cmd_code  <= data_s[7:0];
          param_idx <= 8'h00;
          word_cnt  <= 8'h00;
          case (data_s[7:0])
            8'h2A: state <= ST_CASET;
            8'h2B: state <= ST_PASET;
            8'h2C: begin
              state <= ST_RAMWR;
              ptr_x <= xs;
              ptr_y <= ys;
            end
            8'h3C:   state <= ST_RAMWR;
            8'hD3:   state <= ST_RDID;
            default: state <= ST_IDLE;
          endcase
        end else begin
          param_data <= data_s;
          param_idx  <= word_cnt;
          word_cnt   <= word_cnt_inc;
          case (state)
            ST_RAMWR: begin
              pix_valid <= 1'b1;
              pix_x     <= ptr_x;
              pix_y     <= ptr_y;
              if (x_wrap) begin
                ptr_x <= xs;
                ptr_y <= y_wrap ? ys : ptr_y + 1'b1;
              end else begin
                ptr_x <= ptr_x + 1'b1;
              end
            end
            ST_CASET, ST_PASET: begin
              param_valid <= 1'b1;
              case (word_cnt)
                8'd0: sh_start_hi <= data_s[7:0];
                8'd1: sh_start_lo <= data_s[7:0];
                8'd2: sh_end_hi   <= data_s[7:0];
                8'd3: begin
                  if (state == ST_CASET) begin
                    xs <= COORD_WIDTH'({sh_start_hi, sh_start_lo});
                    xe <= COORD_WIDTH'({sh_end_hi, data_s[7:0]});
                  end else begin
                    ys <= COORD_WIDTH'({sh_start_hi, sh_start_lo});
                    ye <= COORD_WIDTH'({sh_end_hi, data_s[7:0]});
                  end
                end
                default: ;
              endcase
            end
            default: param_valid <= 1'b1;
          endcase
        end
      end else if (rd_fall) begin
        oe_q       <= 1'b1;
        data_out_q <= rd_word;
      end else if (oe_q && (rd_rise || cs_rise)) begin
        oe_q <= 1'b0;
        if (rd_rise && !cs_s) begin
          param_idx <= word_cnt;
          word_cnt  <= word_cnt_inc;
        end
      end
    end
  end

  assign bus.LCD_DATA_OUT = data_out_q;
  assign bus.LCD_DATA_OE  = oe_q;

endmodule
